// File: rtl/rfPhoenixPkg.sv
// Shared rfPhoenix core types used by the 128-bit multicycle ALU scheduler.
package rfPhoenixPkg;

    localparam int MCALU128_LAT = 8;

    typedef logic [31:0]  instruction_t;
    typedef logic [127:0] quad_value_t;
    typedef logic [7:0]   Tid;

    localparam instruction_t NOP_INSN = '0;
    localparam instruction_t FADD128  = 32'h0000_0051;

endpackage

// File: rtl/rfphoenix_mcalu128_sched_pkg.sv
// Local types for the MCALU128 scheduler: the result-buffer entry layout.
package rfphoenix_mcalu128_sched_pkg;
    import rfPhoenixPkg::*;

    typedef struct packed {
        Tid          tid;
        quad_value_t res;
    } mcalu_res_t;

    localparam int RES_W = $bits(mcalu_res_t);

endpackage

// File: rtl/rfphoenix_mcalu128_resfifo.sv
// First-word-fall-through result buffer with synchronous flush.
module rfphoenix_mcalu128_resfifo #(
    parameter int WIDTH = 136,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_eff;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign valid_o = (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign pop_eff = pop_i & valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i)  wr_q <= ptr_inc(wr_q);
            if (pop_eff) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/rfphoenix_mcalu128_sched.sv
// Issue scheduler for the fixed-latency 128-bit multicycle ALU.
// Define RFP_MCALU128_RR_EN for round-robin grant; default is fixed priority.
module rfphoenix_mcalu128_sched
    import rfPhoenixPkg::*;
    import rfphoenix_mcalu128_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = MCALU128_LAT,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  instruction_t [NREQ-1:0] req_ir,
    input  quad_value_t [NREQ-1:0]  req_a,
    input  quad_value_t [NREQ-1:0]  req_b,
    input  quad_value_t [NREQ-1:0]  req_c,
    input  Tid [NREQ-1:0]           req_tid,
    output instruction_t            alu_ir,
    output quad_value_t             alu_a,
    output quad_value_t             alu_b,
    output quad_value_t             alu_c,
    output Tid                      alu_ridi,
    input  quad_value_t             alu_o,
    input  Tid                      alu_rido,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output Tid                      wb_tid,
    output quad_value_t             wb_res,
    output logic                    busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CW-1:0]   credit_q, credit_d;
    logic [LAT:0]    vld_q;
    logic [PW-1:0]   sel;
    logic            accept, push, pop;
    instruction_t    ir_q;
    quad_value_t     a_q, b_q, c_q;
    Tid              tid_q;
    mcalu_res_t      wr_ent, rd_ent;

`ifdef RFP_MCALU128_RR_EN
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   cand;
`endif

    always_comb begin
        req_ready = '0;
        sel       = '0;
        accept    = 1'b0;
`ifdef RFP_MCALU128_RR_EN
        cand      = '0;
`endif
        if (rst && !flush && (credit_q < CW'(DEPTH))) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef RFP_MCALU128_RR_EN
                cand = PW'((32'(ptr_q) + k) % NREQ);
                if (!accept && req_valid[cand]) begin
                    sel    = cand;
                    accept = 1'b1;
                end
`else
                if (!accept && req_valid[k]) begin
                    sel    = PW'(k);
                    accept = 1'b1;
                end
`endif
            end
        end
        if (accept) req_ready[sel] = 1'b1;
    end

`ifdef RFP_MCALU128_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ptr_q <= '0;
        else if (accept) ptr_q <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
    end
`endif

    // Operands hold between issues; only the opcode drops back to NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            tid_q <= '0;
        end else if (accept) begin
            ir_q  <= req_ir[sel];
            a_q   <= req_a[sel];
            b_q   <= req_b[sel];
            c_q   <= req_c[sel];
            tid_q <= req_tid[sel];
        end else begin
            ir_q  <= '0;
        end
    end

    assign alu_ir   = ir_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_c    = c_q;
    assign alu_ridi = tid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       vld_q <= '0;
        else if (flush) vld_q <= '0;
        else            vld_q <= {vld_q[LAT-1:0], accept};
    end

    assign push = vld_q[LAT] & ~flush;
    assign pop  = wb_valid & wb_ready & ~flush;

    always_comb begin
        credit_d = credit_q;
        if (flush) credit_d = '0;
        else       credit_d = credit_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) credit_q <= '0;
        else      credit_q <= credit_d;
    end

    assign busy       = (credit_q != '0);
    assign wr_ent.tid = alu_rido;
    assign wr_ent.res = alu_o;

    rfphoenix_mcalu128_resfifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_resfifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (push),
        .din_i   (wr_ent),
        .pop_i   (pop),
        .dout_o  (rd_ent),
        .valid_o (wb_valid)
    );

    assign wb_tid = rd_ent.tid;
    assign wb_res = rd_ent.res;

endmodule

// File: doc/rfphoenix_mcalu128_sched.md
RFPHOENIX_MCALU128_SCHED -- requirements
Module: rfphoenix_mcalu128_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesting thread slots.
REQ-002 SHALL have parameter LAT, default MCALU128_LAT (8), fixed 128-bit multicycle ALU latency in clocks, inputs to o/rido.
REQ-003 SHALL have parameter DEPTH, default 16, result FIFO entries; DEPTH >= LAT+1 required.
REQ-004 SHALL have ports, clock and reset first; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all in-flight and buffered results
- req_valid  in  NREQ  per-slot request
- req_ready  out  NREQ  per-slot grant (accept = valid&ready at edge)
- req_ir  in  NREQ x instruction_t  opcode per slot
- req_a/req_b/req_c  in  NREQ x quad_value_t  operands
- req_tid  in  NREQ x Tid  thread id
- alu_ir  out  instruction_t  to ALU ir
- alu_a/alu_b/alu_c  out  quad_value_t  to ALU a/b/c
- alu_ridi  out  Tid  to ALU ridi
- alu_o  in  quad_value_t  ALU result
- alu_rido  in  Tid  ALU returned id
- wb_valid  out  1  result available
- wb_ready  in  1  consumer takes result
- wb_tid  out  Tid  result thread id
- wb_res  out  quad_value_t  result value
- busy  out  1  any op in flight or buffered

Function
REQ-005 SHALL assert at most one req_ready bit per cycle, only for a slot with req_valid high, and only when credit < DEPTH and flush low.
REQ-006 SHALL register the accepted slot's ir/a/b/c/tid onto alu_* on the acceptance edge; with no acceptance, alu_ir SHALL be all-zero (NOP) and alu_a/b/c/ridi SHALL hold.
REQ-007 SHALL track issued ops in a LAT+1-stage valid shift register; no reliance on alu_rido for validity.
REQ-008 SHALL write {alu_rido, alu_o} into the FIFO on the edge where the valid bit exits the shift register, i.e. LAT+1 edges after acceptance.
REQ-009 SHALL present FIFO head combinationally (first-word-fall-through); with empty FIFO, wb_valid SHALL rise in the cycle after edge acceptance+LAT+1 (9 edges for LAT=8).
REQ-010 SHALL pop the FIFO on wb_valid&wb_ready; results leave in issue order.
REQ-011 SHALL keep credit = in-flight + FIFO occupancy; +1 on accept, -1 on pop, unchanged when both occur in one cycle; pop in the same cycle does not unblock accept.
REQ-012 SHALL never overflow the FIFO; credit == DEPTH blocks all grants.
REQ-013 SHALL drive busy = (credit != 0).
REQ-014 On flush: clear valid shift register, FIFO, credit; wb_valid low next cycle; no accept in the flush cycle; alu_ir NOP next cycle; ops already in the ALU SHALL be dropped on exit.
REQ-015 Flush and wb_ready in the same cycle: flush wins, no pop counted.

Reset
REQ-016 While rst low: req_ready=0, wb_valid=0, busy=0, credit=0, valid pipe=0, FIFO empty, alu_ir/a/b/c/ridi=0, arbiter pointer=0.
REQ-017 Reset mid-operation SHALL discard all in-flight results; first grant possible on the first edge after rst rises.

Configuration
REQ-018 Macro RFP_MCALU128_RR_EN defined: round-robin grant, search starts at slot after last granted, pointer advances only on accept.
REQ-019 Macro undefined: fixed priority, lowest slot index wins; no pointer state.

Structure
REQ-020 instruction_t, quad_value_t, Tid and constant MCALU128_LAT SHALL come from rfPhoenixPkg; no local redefinition.
REQ-021 Result buffer SHALL be a sub-module rfphoenix_mcalu128_resfifo (width $bits(Tid)+128, depth DEPTH, sync flush, FWFT); arbiter and credit logic inline.

Verification
REQ-022 Single op: slot 0 FADD128 tid=3, wb_ready=1 -> alu_ir set next cycle; wb_valid in cycle after 9th edge, wb_tid=3, busy low one cycle later.
REQ-023 All 4 slots valid continuously, RR_EN -> grants 0,1,2,3,0,... one per cycle; without macro -> slot 0 every cycle.
REQ-024 wb_ready=0, slot 1 streaming -> exactly 16 accepts then req_ready low; one pop -> exactly one further accept.
REQ-025 5 ops issued, flush on cycle 3 -> no wb_valid ever for those ops, credit=0, busy low next cycle.
REQ-026 rst low while 3 ops in flight, release -> all outputs at reset values, no stale wb_valid within 20 cycles.
REQ-027 Credit at DEPTH, pop and request in same cycle -> no accept that cycle, accept next cycle, credit stays DEPTH.
